// File: rtl/fifo_packer_pkg.sv
// ============================================================================
// Module      : fifo_packer_pkg
// Description : Shared state encoding and width helpers for the FIFO packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_packer_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Lane counter width; never below one bit so the register always exists.
    function automatic int cnt_w(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

    // Output count width, sized to hold the value PACK itself.
    function automatic int ocnt_w(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_packer_if.sv
// ============================================================================
// Module      : fifo_packer_if
// Description : FIFO drain side and packed-word handshake side of the packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_packer_if
    import fifo_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int PACK       = 4
);

    localparam int c_ocnt_w = ocnt_w(PACK);

    logic [DATA_WIDTH-1:0]      fifo_dout;
    logic                       fifo_empty;
    logic                       fifo_pop;
    logic                       flush;
    logic [DATA_WIDTH*PACK-1:0] out_data;
    logic [c_ocnt_w-1:0]        out_count;
    logic                       out_valid;
    logic                       out_ready;

    // The packer itself.
    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  flush,
        input  out_ready,
        output fifo_pop,
        output out_data,
        output out_count,
        output out_valid
    );

    // The surrounding FIFO and downstream consumer.
    modport slave (
        output fifo_dout,
        output fifo_empty,
        output flush,
        output out_ready,
        input  fifo_pop,
        input  out_data,
        input  out_count,
        input  out_valid
    );

endinterface

`default_nettype wire

// File: rtl/fifo_packer.sv
// ============================================================================
// Module      : fifo_packer
// Description : Drains a FWFT FIFO and packs PACK entries into one wide word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_packer
    import fifo_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int PACK       = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    fifo_packer_if.master bus
);

    localparam int                  c_cnt_w     = cnt_w(PACK);
    localparam int                  c_ocnt_w    = ocnt_w(PACK);
    localparam logic [c_cnt_w-1:0]  c_last_lane = c_cnt_w'(PACK - 1);
    localparam logic [c_ocnt_w-1:0] c_full      = c_ocnt_w'(PACK);

    state_t                     r_state;
    logic [c_cnt_w-1:0]         r_cnt;
    logic [DATA_WIDTH*PACK-1:0] r_data;
    logic [c_ocnt_w-1:0]        r_count;

    state_t                     w_state_nxt;
    logic [c_cnt_w-1:0]         w_cnt_nxt;
    logic [DATA_WIDTH*PACK-1:0] w_data_nxt;
    logic [c_ocnt_w-1:0]        w_count_nxt;
    logic [c_ocnt_w-1:0]        w_fill_n;
    logic                       w_pop;

    // In HOLD the pop depends combinationally on out_ready so the next word
    // can start in the same cycle the current one is accepted.
    assign w_pop    = !bus.fifo_empty && ((r_state == FILL) || bus.out_ready);
    assign w_fill_n = c_ocnt_w'(r_cnt) + c_ocnt_w'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_count_nxt = r_count;
        unique case (r_state)
            FILL: begin
                if (w_pop) begin
                    w_data_nxt[int'(r_cnt)*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_dout;
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                if (w_pop && (r_cnt == c_last_lane)) begin
                    w_state_nxt = HOLD;
                    w_count_nxt = c_full;
                    w_cnt_nxt   = '0;
                end else if (bus.flush && (w_fill_n != '0)) begin
                    w_state_nxt = HOLD;
                    w_count_nxt = w_fill_n;
                    w_cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    // Clearing here keeps unwritten lanes of a partial word at zero.
                    w_state_nxt = FILL;
                    w_data_nxt  = '0;
                    w_cnt_nxt   = '0;
                    if (w_pop) begin
                        w_data_nxt[DATA_WIDTH-1:0] = bus.fifo_dout;
                        w_cnt_nxt                  = c_cnt_w'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_cnt_nxt   = '0;
                w_data_nxt  = '0;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign bus.fifo_pop  = w_pop;
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_data  = r_data;
    assign bus.out_count = r_count;

endmodule

`default_nettype wire
